vga_frame_reader: RTL

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
//
// Purpose:
//   Generates standard VGA timing, from a 640x480 mode by default, and
//   displays a fixed-size image window. Pixels are fetched from a memory
//   stage through read port B. The ROM image sits at address 0, and the RAM
//   (processed) image sits at RAM_BASE. The source is chosen once per frame
//   from src_sel.
//
// Ports:
//   clk          pixel clock; it also clocks memory port B
//   rst          synchronous, active-high reset
//   src_sel      0 = ROM image, 1 = RAM image (taken at frame boundary)
//   address_b    port-B read address (combinational from registered state)
//   read_data_b  port-B read data, valid 2 cycles after address_b
//   vga_r/g/b    pixel colour (registered)
//   vga_hsync    horizontal sync, active-low (registered)
//   vga_vsync    vertical sync, active-low (registered)
//   vga_blank_n  high during the visible area (registered)
//   frame_done   one-cycle pulse in the cycle after the last counter state
//
// Memory interface: there is no valid/ready handshake. Port B is read
// unconditionally every cycle. Data for the address presented in cycle t is
// consumed in cycle t+2.
// -----------------------------------------------------------------------------
module vga_frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int IMG_W    = 300,
   parameter int IMG_H    = 300,
   parameter int X0       = 170,
   parameter int Y0       = 90,
   parameter int RAM_BASE = 90300
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        src_sel,
   output logic [17:0] address_b,
   input  logic [23:0] read_data_b,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank_n,
   output logic        frame_done
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Sized boundary constants keep every comparison at the counter width.
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  WIN_X0   = 10'(X0);
   localparam logic [9:0]  WIN_X1   = 10'(X0 + IMG_W);
   localparam logic [9:0]  WIN_Y0   = 10'(Y0);
   localparam logic [9:0]  WIN_Y1   = 10'(Y0 + IMG_H);
   localparam logic [17:0] BASE_RAM = 18'(RAM_BASE);

   // Counter state (cycle t)
   logic [9:0]  h;
   logic [9:0]  v;
   logic [16:0] idx;
   logic        src_q;

   // Raw per-cycle flags, all derived from the counter state of cycle t
   logic frame_end;
   logic raw_hs;
   logic raw_vs;
   logic raw_vis;
   logic raw_win;

   // Two alignment stages that match the 2-cycle memory read latency
   logic p1_hs, p1_vs, p1_vis, p1_win;
   logic p2_hs, p2_vs, p2_vis, p2_win;

   assign frame_end = (h == H_LAST) && (v == V_LAST);
   assign raw_hs    = !((h >= HS_START) && (h < HS_END));
   assign raw_vs    = !((v >= VS_START) && (v < VS_END));
   assign raw_vis   = (h < H_VIS) && (v < V_VIS);
   assign raw_win   = (h >= WIN_X0) && (h < WIN_X1) &&
                      (v >= WIN_Y0) && (v < WIN_Y1);

   // The address depends only on registered state, so it holds steady
   // between window pixels and advances only after a window cycle.
   assign address_b = (src_q ? BASE_RAM : 18'd0) + {1'b0, idx};

   // Horizontal and vertical counters
   always_ff @(posedge clk) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
         h <= h + 10'd1;
      end
   end

   // Pixel index and the frame-latched source select. Both are sampled in
   // the last counter state, so the new source takes effect exactly at the
   // frame start and a mid-frame toggle of src_sel cannot tear the image.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         src_q <= 1'b0;
      end else if (frame_end) begin
         idx   <= '0;
         src_q <= src_sel;
      end else if (raw_win) begin
         idx   <= idx + 17'd1;
      end
   end

   // Flag alignment pipeline. The sync flags reset to 1, their inactive level.
   always_ff @(posedge clk) begin
      if (rst) begin
         p1_hs  <= 1'b1;
         p1_vs  <= 1'b1;
         p1_vis <= 1'b0;
         p1_win <= 1'b0;
         p2_hs  <= 1'b1;
         p2_vs  <= 1'b1;
         p2_vis <= 1'b0;
         p2_win <= 1'b0;
      end else begin
         p1_hs  <= raw_hs;
         p1_vs  <= raw_vs;
         p1_vis <= raw_vis;
         p1_win <= raw_win;
         p2_hs  <= p1_hs;
         p2_vs  <= p1_vs;
         p2_vis <= p1_vis;
         p2_win <= p1_win;
      end
   end

   // Output registers. Colour comes from memory only inside the window; the
   // memory is still read outside it, so its data must be masked here.
   always_ff @(posedge clk) begin
      if (rst) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_blank_n <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         if (p2_win) begin
            vga_r <= read_data_b[23:16];
            vga_g <= read_data_b[15:8];
            vga_b <= read_data_b[7:0];
         end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
         end
         vga_hsync   <= p2_hs;
         vga_vsync   <= p2_vs;
         vga_blank_n <= p2_vis;
         frame_done  <= frame_end;
      end
   end

endmodule
